// File: rtl/iter_addr_gen_v2.sv
// iter_addr_gen_v2: loop address generator for three operands.
//
// Two tables, base and stride, hold NUM_NS x 2^NS_INDEX_ID_BITS entries each. A start
// launches a loop of loop_count iterations. Each operand's base and stride are copied into
// private working registers. One address triple is then emitted per valid/ready handshake,
// and every address advances by its own stride.
//
// Ports:
//   clk, reset_n                          clock, async active-low reset
//   cfg_valid, cfg_is_stride              table write strobe, 0 = base table, 1 = stride table
//   cfg_ns_id, cfg_index, cfg_data        table write target and data
//   start, loop_count                     loop launch (accepted only when idle)
//   src1/src2/dest_ns_id, *_idx           operand iterators, sampled with start
//   busy, done                            not-idle flag, 1-cycle completion pulse
//   addr_valid, addr_ready, last          address stream handshake, final-iteration flag
//   src1_addr, src2_addr, dest_addr       per-iteration addresses
//
// Build option: define ITER_WRITEBACK_EN to write the final working addresses back into the
// base table when a non-empty loop completes.
module iter_addr_gen_v2 #(
    parameter int unsigned NUM_NS           = 6,
    parameter int unsigned NS_ID_BITS       = 3,
    parameter int unsigned NS_INDEX_ID_BITS = 5,
    parameter int unsigned ADDR_WIDTH       = 32,
    parameter int unsigned LOOP_CNT_WIDTH   = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        cfg_valid,
    input  logic                        cfg_is_stride,
    input  logic [NS_ID_BITS-1:0]       cfg_ns_id,
    input  logic [NS_INDEX_ID_BITS-1:0] cfg_index,
    input  logic [ADDR_WIDTH-1:0]       cfg_data,
    input  logic                        start,
    input  logic [LOOP_CNT_WIDTH-1:0]   loop_count,
    input  logic [NS_ID_BITS-1:0]       src1_ns_id,
    input  logic [NS_ID_BITS-1:0]       src2_ns_id,
    input  logic [NS_ID_BITS-1:0]       dest_ns_id,
    input  logic [NS_INDEX_ID_BITS-1:0] src1_idx,
    input  logic [NS_INDEX_ID_BITS-1:0] src2_idx,
    input  logic [NS_INDEX_ID_BITS-1:0] dest_idx,
    output logic                        busy,
    output logic                        done,
    output logic                        addr_valid,
    input  logic                        addr_ready,
    output logic                        last,
    output logic [ADDR_WIDTH-1:0]       src1_addr,
    output logic [ADDR_WIDTH-1:0]       src2_addr,
    output logic [ADDR_WIDTH-1:0]       dest_addr
);

    localparam int unsigned Depth = 1 << NS_INDEX_ID_BITS;
    localparam logic [NS_ID_BITS:0] NumNsW = NUM_NS[NS_ID_BITS:0];

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    state_e r_state, w_state_next;

    logic [ADDR_WIDTH-1:0]       r_base_tbl   [NUM_NS][Depth];
    logic [ADDR_WIDTH-1:0]       r_stride_tbl [NUM_NS][Depth];

    // Operand 0 = src1, 1 = src2, 2 = dest.
    logic [NS_ID_BITS-1:0]       r_ns     [3];
    logic [NS_INDEX_ID_BITS-1:0] r_idx    [3];
    logic [ADDR_WIDTH-1:0]       r_addr   [3];
    logic [ADDR_WIDTH-1:0]       r_stride [3];
    logic [LOOP_CNT_WIDTH-1:0]   r_rem;

    logic [2:0]                  w_ns_ok;
    logic [ADDR_WIDTH-1:0]       w_rd_base   [3];
    logic [ADDR_WIDTH-1:0]       w_rd_stride [3];
    logic                        w_cfg_ok;
    logic                        w_hs;

    assign busy       = (r_state != StIdle);
    assign done       = (r_state == StDone);
    assign addr_valid = (r_state == StRun);
    assign last       = addr_valid && (r_rem == LOOP_CNT_WIDTH'(1));
    assign src1_addr  = r_addr[0];
    assign src2_addr  = r_addr[1];
    assign dest_addr  = r_addr[2];
    assign w_hs       = addr_valid && addr_ready;
    assign w_cfg_ok   = cfg_valid && ({1'b0, cfg_ns_id} < NumNsW);

    // Out-of-range namespaces read as base 0 / stride 0.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            w_ns_ok[k]     = ({1'b0, r_ns[k]} < NumNsW);
            w_rd_base[k]   = '0;
            w_rd_stride[k] = '0;
            if (w_ns_ok[k]) begin
                w_rd_base[k]   = r_base_tbl[r_ns[k]][r_idx[k]];
                w_rd_stride[k] = r_stride_tbl[r_ns[k]][r_idx[k]];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (start) w_state_next = (loop_count == '0) ? StDone : StLoad;
            StLoad:  w_state_next = StRun;
            StRun:   if (w_hs && last) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

`ifdef ITER_WRITEBACK_EN
    // Marks a zero-count loop so the completion cycle skips the write-back.
    logic r_zero;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_zero <= 1'b0;
        end else if (r_state == StIdle && start) begin
            r_zero <= (loop_count == '0);
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rem <= '0;
            for (int k = 0; k < 3; k++) begin
                r_ns[k]     <= '0;
                r_idx[k]    <= '0;
                r_addr[k]   <= '0;
                r_stride[k] <= '0;
            end
        end else begin
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_rem    <= loop_count;
                        r_ns[0]  <= src1_ns_id;
                        r_ns[1]  <= src2_ns_id;
                        r_ns[2]  <= dest_ns_id;
                        r_idx[0] <= src1_idx;
                        r_idx[1] <= src2_idx;
                        r_idx[2] <= dest_idx;
                    end
                end
                StLoad: begin
                    for (int k = 0; k < 3; k++) begin
                        r_addr[k]   <= w_rd_base[k];
                        r_stride[k] <= w_rd_stride[k];
                    end
                end
                StRun: begin
                    if (w_hs) begin
                        r_rem <= r_rem - LOOP_CNT_WIDTH'(1);
                        for (int k = 0; k < 3; k++) begin
                            r_addr[k] <= r_addr[k] + r_stride[k];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // A write in the LOAD cycle lands at the same edge as the copy, so the copy sees old data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned n = 0; n < NUM_NS; n++) begin
                for (int unsigned i = 0; i < Depth; i++) begin
                    r_base_tbl[n][i]   <= '0;
                    r_stride_tbl[n][i] <= '0;
                end
            end
        end else begin
            if (w_cfg_ok) begin
                if (cfg_is_stride) begin
                    r_stride_tbl[cfg_ns_id][cfg_index] <= cfg_data;
                end else begin
                    r_base_tbl[cfg_ns_id][cfg_index] <= cfg_data;
                end
            end
`ifdef ITER_WRITEBACK_EN
            // Placed after the cfg write so the write-back wins on a collision. Operands that
            // share an entry carry identical values, so they collapse to one write.
            if (r_state == StDone && !r_zero) begin
                for (int k = 0; k < 3; k++) begin
                    if (w_ns_ok[k]) begin
                        r_base_tbl[r_ns[k]][r_idx[k]] <= r_addr[k];
                    end
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_iter_addr_gen_v2.sv
module tb_iter_addr_gen_v2;

    logic        clk;
    logic        reset_n;
    logic        cfg_valid, cfg_is_stride;
    logic [2:0]  cfg_ns_id;
    logic [4:0]  cfg_index;
    logic [31:0] cfg_data;
    logic        start;
    logic [15:0] loop_count;
    logic [2:0]  src1_ns_id, src2_ns_id, dest_ns_id;
    logic [4:0]  src1_idx, src2_idx, dest_idx;
    logic        busy, done, addr_valid, addr_ready, last;
    logic [31:0] src1_addr, src2_addr, dest_addr;

    int total = 0;
    int bad   = 0;

    iter_addr_gen_v2 dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_valid(cfg_valid), .cfg_is_stride(cfg_is_stride),
        .cfg_ns_id(cfg_ns_id), .cfg_index(cfg_index), .cfg_data(cfg_data),
        .start(start), .loop_count(loop_count),
        .src1_ns_id(src1_ns_id), .src2_ns_id(src2_ns_id), .dest_ns_id(dest_ns_id),
        .src1_idx(src1_idx), .src2_idx(src2_idx), .dest_idx(dest_idx),
        .busy(busy), .done(done), .addr_valid(addr_valid), .addr_ready(addr_ready),
        .last(last), .src1_addr(src1_addr), .src2_addr(src2_addr), .dest_addr(dest_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tables plus a description of the loop in flight: which phase of its life it is in,
    // how many handshakes have happened, and the base/stride snapshot taken at load time.
    logic [31:0] m_base   [8][32];
    logic [31:0] m_stride [8][32];
    int          m_phase;  // 0 idle, 1 load, 2 emitting, 3 completion
    int          m_n, m_i;
    bit          m_zero;
    logic [2:0]  m_ns  [3];
    logic [4:0]  m_idx [3];
    logic [31:0] m_b   [3];
    logic [31:0] m_s   [3];

    function automatic logic [31:0] m_addr(input int k);
        return m_b[k] + m_s[k] * 32'(m_i);
    endfunction

    task automatic mdl_reset();
        for (int n = 0; n < 8; n++)
            for (int i = 0; i < 32; i++) begin
                m_base[n][i]   = '0;
                m_stride[n][i] = '0;
            end
        m_phase = 0; m_n = 0; m_i = 0; m_zero = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m_ns[k] = '0; m_idx[k] = '0; m_b[k] = '0; m_s[k] = '0;
        end
    endtask

    // Advance the model across the coming rising edge using the inputs it will sample.
    task automatic mdl_step();
        bit wb;
        wb = 1'b0;
        case (m_phase)
            0: if (start) begin
                m_zero = (loop_count == 0);
                m_n    = int'(loop_count);
                m_phase = m_zero ? 3 : 1;
                m_ns[0] = src1_ns_id; m_ns[1] = src2_ns_id; m_ns[2] = dest_ns_id;
                m_idx[0] = src1_idx;  m_idx[1] = src2_idx;  m_idx[2] = dest_idx;
            end
            1: begin
                for (int k = 0; k < 3; k++) begin
                    m_b[k] = (m_ns[k] < 6) ? m_base[m_ns[k]][m_idx[k]] : 32'h0;
                    m_s[k] = (m_ns[k] < 6) ? m_stride[m_ns[k]][m_idx[k]] : 32'h0;
                end
                m_i = 0;
                m_phase = 2;
            end
            2: if (addr_ready) begin
                m_i++;
                if (m_i == m_n) m_phase = 3;
            end
            default: begin
                wb = !m_zero;
                m_phase = 0;
            end
        endcase
        if (cfg_valid && cfg_ns_id < 6) begin
            if (cfg_is_stride) m_stride[cfg_ns_id][cfg_index] = cfg_data;
            else               m_base[cfg_ns_id][cfg_index]   = cfg_data;
        end
`ifdef ITER_WRITEBACK_EN
        if (wb)
            for (int k = 0; k < 3; k++)
                if (m_ns[k] < 6) m_base[m_ns[k]][m_idx[k]] = m_b[k] + m_s[k] * 32'(m_n);
`else
        if (wb) m_zero = m_zero;
`endif
    endtask

    // Compare process: every falling edge, DUT against model, then advance the model.
    initial begin
        mdl_reset();
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                mdl_reset();
                chk("rst_busy", {31'b0, busy}, 32'h0);
                chk("rst_done", {31'b0, done}, 32'h0);
                chk("rst_valid", {31'b0, addr_valid}, 32'h0);
                chk("rst_last", {31'b0, last}, 32'h0);
                chk("rst_src1", src1_addr, 32'h0);
                chk("rst_src2", src2_addr, 32'h0);
                chk("rst_dest", dest_addr, 32'h0);
            end else begin
                chk("busy", {31'b0, busy}, {31'b0, m_phase != 0});
                chk("done", {31'b0, done}, {31'b0, m_phase == 3});
                chk("addr_valid", {31'b0, addr_valid}, {31'b0, m_phase == 2});
                if (m_phase == 2) begin
                    chk("src1_addr", src1_addr, m_addr(0));
                    chk("src2_addr", src2_addr, m_addr(1));
                    chk("dest_addr", dest_addr, m_addr(2));
                    chk("last", {31'b0, last}, {31'b0, m_i == m_n - 1});
                end else begin
                    chk("last_idle", {31'b0, last}, 32'h0);
                end
                mdl_step();
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input bit is_s, input logic [2:0] ns, input logic [4:0] idx,
                       input logic [31:0] d);
        cfg_valid = 1'b1; cfg_is_stride = is_s; cfg_ns_id = ns; cfg_index = idx; cfg_data = d;
        tick();
        cfg_valid = 1'b0;
    endtask

    // Presents start for one sampling edge; returns just after that edge.
    task automatic launch(input logic [15:0] n, input logic [2:0] n1, input logic [4:0] i1,
                          input logic [2:0] n2, input logic [4:0] i2,
                          input logic [2:0] nd, input logic [4:0] id);
        start = 1'b1; loop_count = n;
        src1_ns_id = n1; src1_idx = i1; src2_ns_id = n2; src2_idx = i2;
        dest_ns_id = nd; dest_idx = id;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; cfg_valid = 1'b0; cfg_is_stride = 1'b0; cfg_ns_id = '0; cfg_index = '0;
        cfg_data = '0; start = 1'b0; loop_count = '0; addr_ready = 1'b1;
        src1_ns_id = '0; src2_ns_id = '0; dest_ns_id = '0;
        src1_idx = '0; src2_idx = '0; dest_idx = '0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1 reset_n = 1'b1;

        // Basic loop; dest reads ns7, which is outside the table and must stay 0.
        cfg(1'b0, 3'd1, 5'd2, 32'h100);
        cfg(1'b1, 3'd1, 5'd2, 32'h4);
        cfg(1'b0, 3'd7, 5'd0, 32'hDEAD);
        launch(16'd3, 3'd1, 5'd2, 3'd0, 5'd0, 3'd7, 5'd0);
        @(negedge clk); chk("lit_load_novalid", {31'b0, addr_valid}, 32'h0);
        @(negedge clk); chk("lit_a0", src1_addr, 32'h100);
        chk("lit_ns7", dest_addr, 32'h0);
        @(negedge clk); chk("lit_a1", src1_addr, 32'h104);
        @(negedge clk); chk("lit_a2", src1_addr, 32'h108);
        chk("lit_last", {31'b0, last}, 32'h1);
        @(negedge clk); chk("lit_done", {31'b0, done}, 32'h1);
        tick(); tick();

        // Backpressure on the second iteration. Re-seed the base because a write-back may
        // have moved it.
        cfg(1'b0, 3'd1, 5'd2, 32'h100);
        launch(16'd3, 3'd1, 5'd2, 3'd0, 5'd0, 3'd7, 5'd0);
        tick(); tick();
        addr_ready = 1'b0;
        @(negedge clk); chk("lit_hold0", src1_addr, 32'h104);
        tick();
        @(negedge clk); chk("lit_hold1", src1_addr, 32'h104);
        tick();
        addr_ready = 1'b1;
        @(negedge clk); chk("lit_hold2", src1_addr, 32'h104);
        tick();
        @(negedge clk); chk("lit_after", src1_addr, 32'h108);
        tick(); tick(); tick();

        // Address wrap, and the base-table write-back when it is built in.
        cfg(1'b0, 3'd2, 5'd0, 32'hFFFF_FFFC);
        cfg(1'b1, 3'd2, 5'd0, 32'h8);
        launch(16'd2, 3'd0, 5'd1, 3'd2, 5'd0, 3'd0, 5'd1);
        @(negedge clk);
        @(negedge clk); chk("lit_wrap0", src2_addr, 32'hFFFF_FFFC);
        @(negedge clk); chk("lit_wrap1", src2_addr, 32'h0000_0004);
        tick(); tick(); tick();
        launch(16'd1, 3'd0, 5'd1, 3'd2, 5'd0, 3'd0, 5'd1);
        @(negedge clk);
        @(negedge clk);
`ifdef ITER_WRITEBACK_EN
        chk("lit_wb", src2_addr, 32'h0000_000C);
`else
        chk("lit_nowb", src2_addr, 32'hFFFF_FFFC);
`endif
        tick(); tick(); tick();

        // Zero-count loop, then a start presented while busy.
        launch(16'd0, 3'd1, 5'd2, 3'd0, 5'd0, 3'd0, 5'd0);
        @(negedge clk); chk("lit_zero_done", {31'b0, done}, 32'h1);
        chk("lit_zero_novalid", {31'b0, addr_valid}, 32'h0);
        tick(); tick();
        launch(16'd2, 3'd1, 5'd2, 3'd0, 5'd0, 3'd0, 5'd0);
        launch(16'd5, 3'd2, 5'd0, 3'd2, 5'd0, 3'd2, 5'd0);
        repeat (6) tick();

        // Reset in the middle of a loop.
        launch(16'd4, 3'd1, 5'd2, 3'd0, 5'd0, 3'd0, 5'd0);
        tick(); tick();
        #2 reset_n = 1'b0;
        #1;
        chk("lit_rst_busy", {31'b0, busy}, 32'h0);
        chk("lit_rst_valid", {31'b0, addr_valid}, 32'h0);
        chk("lit_rst_src1", src1_addr, 32'h0);
        @(posedge clk); #1 reset_n = 1'b1;
        cfg(1'b1, 3'd1, 5'd2, 32'h4);
        launch(16'd1, 3'd1, 5'd2, 3'd0, 5'd0, 3'd0, 5'd0);
        @(negedge clk);
        @(negedge clk); chk("lit_cleared", src1_addr, 32'h0);
        tick(); tick(); tick();

        // Random traffic: writes in any state, colliding operands, starts while busy.
        for (int c = 0; c < 2500; c++) begin
            cfg_valid     = ($urandom_range(0, 9) < 3);
            cfg_is_stride = 1'($urandom_range(0, 1));
            cfg_ns_id     = 3'($urandom_range(0, 7));
            cfg_index     = 5'($urandom_range(0, 3));
            cfg_data      = $urandom;
            start         = ($urandom_range(0, 9) < 2);
            loop_count    = 16'($urandom_range(0, 4));
            src1_ns_id    = 3'($urandom_range(0, 7));
            src2_ns_id    = 3'($urandom_range(0, 7));
            dest_ns_id    = 3'($urandom_range(0, 7));
            src1_idx      = 5'($urandom_range(0, 3));
            src2_idx      = 5'($urandom_range(0, 3));
            dest_idx      = 5'($urandom_range(0, 3));
            addr_ready    = ($urandom_range(0, 9) < 7);
            tick();
        end
        cfg_valid = 1'b0; start = 1'b0; addr_ready = 1'b1;
        repeat (12) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
